ifu_idu_queue: RTL and testbench



---
 rtl/ifu_idu_queue.sv | 80 ++++++++
 tb/tb_ifu_idu_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu_idu_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry FIFO with a
// valid/ready fetch side, single-cycle flush and NOP output when empty.
module ifu_idu_queue #(
    parameter int                DEPTH  = 4,
    parameter int                INST_W = 32,
    parameter int                ADDR_W = 32,
    parameter logic [INST_W-1:0] NOP    = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       stall_i,
    input  logic [INST_W-1:0]          inst_i,
    input  logic [ADDR_W-1:0]          inst_addr_i,
    input  logic                       inst_valid_i,
    output logic                       inst_ready_o,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          inst_addr_o,
    output logic                       inst_valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = INST_W + ADDR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_notEmpty;
    logic             w_notFull;
    logic [ENT_W-1:0] w_head;

    // Ready and valid come only from registered occupancy, so a pop in the
    // same cycle never reopens a full queue.
    assign w_notEmpty = (r_count != '0);
    assign w_notFull  = (r_count != FULL_CNT);
    assign w_push     = inst_valid_i & w_notFull & ~flush_i;
    assign w_pop      = w_notEmpty & ~stall_i & ~flush_i;
    assign w_head     = r_mem[r_rdPtr];

    assign count_o      = r_count;
    assign inst_ready_o = w_notFull;
    assign inst_valid_o = w_notEmpty;
    assign inst_o       = w_notEmpty ? w_head[INST_W-1:0] : NOP;
    assign inst_addr_o  = w_notEmpty ? w_head[ENT_W-1:INST_W] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {inst_addr_i, inst_i};
        end
    end

    // Pointers wrap by natural overflow; flush and reset both just clear occupancy.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_idu_queue.sv
// Testbench for ifu_idu_queue: table of directed vectors, hand-written corner
// sequences and a queue-based scoreboard checked every cycle.
module tb_ifu_idu_queue;

    localparam int          DEPTH  = 4;
    localparam int          INST_W = 32;
    localparam int          ADDR_W = 32;
    localparam int          CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic              clk = 1'b0;
    logic              rst;
    logic              flushI;
    logic              stallI;
    logic [INST_W-1:0] instI;
    logic [ADDR_W-1:0] instAddrI;
    logic              instValidI;
    logic              instReadyO;
    logic [INST_W-1:0] instO;
    logic [ADDR_W-1:0] instAddrO;
    logic              instValidO;
    logic [CNT_W-1:0]  countO;

    int assertCount = 0;
    int failCount   = 0;

    logic [63:0] sbQueue [$];

    typedef struct {
        logic        rst;
        logic        flush;
        logic        stall;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] addr;
        int          expCount;
        logic        expValid;
        logic        expReady;
        logic [31:0] expInst;
        logic [31:0] expAddr;
    } vec_t;

    vec_t vecs [$];

    ifu_idu_queue #(
        .DEPTH(DEPTH), .INST_W(INST_W), .ADDR_W(ADDR_W), .NOP(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush_i(flushI),
        .stall_i(stallI),
        .inst_i(instI),
        .inst_addr_i(instAddrI),
        .inst_valid_i(instValidI),
        .inst_ready_o(instReadyO),
        .inst_o(instO),
        .inst_addr_o(instAddrO),
        .inst_valid_o(instValidO),
        .count_o(countO)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] kInst(input int k);
        return 32'h1000_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] kAddr(input int k);
        return 32'h0000_0100 + 32'(4 * k);
    endfunction

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic r, input logic f, input logic s, input logic v,
                          input logic [31:0] inst, input logic [31:0] addr,
                          input int eCnt, input logic eVal, input logic eRdy,
                          input logic [31:0] eInst, input logic [31:0] eAddr);
        vec_t t;
        t.rst = r; t.flush = f; t.stall = s; t.valid = v; t.inst = inst; t.addr = addr;
        t.expCount = eCnt; t.expValid = eVal; t.expReady = eRdy;
        t.expInst = eInst; t.expAddr = eAddr;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic s, input logic v,
                                 input logic [31:0] inst, input logic [31:0] addr);
        rst = r; flushI = f; stallI = s; instValidI = v; instI = inst; instAddrI = addr;
    endtask

    // Scoreboard comparison of the current outputs against the model queue.
    task automatic checkOutput(input string tag);
        int          n;
        logic [63:0] head;
        n    = sbQueue.size();
        head = (n != 0) ? sbQueue[0] : {32'h0, NOP};
        checkValue({tag, " sb count"}, 64'(countO), 64'(n));
        checkValue({tag, " sb valid"}, 64'(instValidO), 64'(n != 0));
        checkValue({tag, " sb ready"}, 64'(instReadyO), 64'(n != DEPTH));
        checkValue({tag, " sb inst"}, 64'(instO), 64'(head[31:0]));
        checkValue({tag, " sb addr"}, 64'(instAddrO), 64'(head[63:32]));
    endtask

    // Advance one edge and update the scoreboard from the inputs just applied.
    task automatic tickModel();
        bit doPush;
        bit doPop;
        doPush = instValidI && (sbQueue.size() != DEPTH) && !flushI;
        doPop  = (sbQueue.size() != 0) && !stallI && !flushI;
        @(posedge clk);
        #1;
        if (rst || flushI) begin
            sbQueue.delete();
        end else begin
            if (doPop) void'(sbQueue.pop_front());
            if (doPush) sbQueue.push_back({instAddrI, instI});
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tickModel();
        tickModel();

        // rst flush stall valid inst addr | count valid ready inst addr
        addVec(0, 0, 0, 0, 0, 0,                          0, 0, 1, NOP, 0);
        addVec(0, 0, 0, 1, 32'h00100093, 32'h80000000,    0, 0, 1, NOP, 0);
        addVec(0, 0, 0, 0, 0, 0,                          1, 1, 1, 32'h00100093, 32'h80000000);
        addVec(0, 0, 0, 0, 0, 0,                          0, 0, 1, NOP, 0);
        addVec(0, 0, 1, 1, kInst(1), kAddr(1),            0, 0, 1, NOP, 0);
        addVec(0, 0, 1, 1, kInst(2), kAddr(2),            1, 1, 1, kInst(1), kAddr(1));
        addVec(0, 0, 1, 1, kInst(3), kAddr(3),            2, 1, 1, kInst(1), kAddr(1));
        addVec(0, 0, 1, 1, kInst(4), kAddr(4),            3, 1, 1, kInst(1), kAddr(1));
        addVec(0, 0, 1, 1, kInst(5), kAddr(5),            4, 1, 0, kInst(1), kAddr(1));
        addVec(0, 0, 0, 1, kInst(5), kAddr(5),            4, 1, 0, kInst(1), kAddr(1));
        addVec(0, 0, 0, 1, kInst(5), kAddr(5),            3, 1, 1, kInst(2), kAddr(2));
        addVec(0, 0, 0, 0, 0, 0,                          3, 1, 1, kInst(3), kAddr(3));
        addVec(0, 0, 0, 0, 0, 0,                          2, 1, 1, kInst(4), kAddr(4));
        addVec(0, 0, 0, 0, 0, 0,                          1, 1, 1, kInst(5), kAddr(5));
        addVec(0, 0, 0, 0, 0, 0,                          0, 0, 1, NOP, 0);
        addVec(0, 0, 1, 1, kInst(6), kAddr(6),            0, 0, 1, NOP, 0);
        addVec(0, 0, 1, 1, kInst(7), kAddr(7),            1, 1, 1, kInst(6), kAddr(6));
        addVec(0, 0, 1, 1, kInst(8), kAddr(8),            2, 1, 1, kInst(6), kAddr(6));
        addVec(0, 1, 1, 1, kInst(9), kAddr(9),            3, 1, 1, kInst(6), kAddr(6));
        addVec(0, 0, 0, 0, 0, 0,                          0, 0, 1, NOP, 0);
        addVec(0, 0, 1, 1, kInst(10), kAddr(10),          0, 0, 1, NOP, 0);
        addVec(0, 0, 1, 1, kInst(11), kAddr(11),          1, 1, 1, kInst(10), kAddr(10));
        addVec(1, 1, 1, 1, kInst(12), kAddr(12),          2, 1, 1, kInst(10), kAddr(10));
        addVec(0, 0, 0, 1, 32'h00100093, 32'h80000000,    0, 0, 1, NOP, 0);
        addVec(0, 0, 0, 0, 0, 0,                          1, 1, 1, 32'h00100093, 32'h80000000);
        addVec(0, 0, 0, 0, 0, 0,                          0, 0, 1, NOP, 0);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].stall, vecs[i].valid,
                          vecs[i].inst, vecs[i].addr);
            checkValue({tag, " count"}, 64'(countO), 64'(vecs[i].expCount));
            checkValue({tag, " valid"}, 64'(instValidO), 64'(vecs[i].expValid));
            checkValue({tag, " ready"}, 64'(instReadyO), 64'(vecs[i].expReady));
            checkValue({tag, " inst"}, 64'(instO), 64'(vecs[i].expInst));
            checkValue({tag, " addr"}, 64'(instAddrO), 64'(vecs[i].expAddr));
            checkOutput(tag);
            tickModel();
        end

        // Streaming with simultaneous push and pop; pointers wrap several times.
        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("stream%0d", i);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0200_0013 + 32'(i), 32'(4 * i));
            if (i > 0) begin
                checkValue({tag, " count"}, 64'(countO), 64'd1);
                checkValue({tag, " addr"}, 64'(instAddrO), 64'(4 * (i - 1)));
            end
            checkOutput(tag);
            tickModel();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkValue("stream tail count", 64'(countO), 64'd1);
        checkValue("stream tail addr", 64'(instAddrO), 64'h4C);
        tickModel();
        checkValue("stream drained valid", 64'(instValidO), 64'd0);
        checkOutput("stream drained");

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            logic r;
            logic f;
            r = ($urandom_range(99) < 2);
            f = ($urandom_range(99) < 5);
            applyStimulus(r, f, ($urandom_range(99) < 40), ($urandom_range(99) < 65),
                          $urandom, $urandom);
            checkOutput($sformatf("rand%0d", i));
            tickModel();
        end
        checkOutput("final");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
